addc_capture_ctrl: RTL and testbench

ADDC_CAPTURE_CTRL -- requirements
Module: addc_capture_ctrl

---
 rtl/addc_capture_ctrl.sv | 160 ++++++++++++++++
 tb/tb_addc_capture_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/addc_capture_ctrl.sv
// ADC capture controller: decimated sample capture into a FIFO with an Avalon-MM
// register interface (CTRL/STATUS, DECIM, COUNT, DATA) and a capture-complete irq.
module addc_capture_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_s0_address,
  input  logic              avs_s0_read,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  output logic [31:0]       avs_s0_readdata,
  input  logic [DATA_W-1:0] addc_hsmc,
  output logic              irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PAD_W = 31 - DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] sample;
  logic [15:0]       decim;
  logic [15:0]       count;
  logic [15:0]       divider;
  logic [15:0]       remaining;
  logic              overflow;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  logic ctrl_wr_c;
  logic start_c;
  logic abort_c;
  logic flush_c;
  logic clr_ovf_c;
  logic empty_c;
  logic full_c;
  logic tick_c;
  logic pop_c;
  logic push_c;
  logic drop_c;
  logic unused_wdata;

  assign unused_wdata = ^avs_s0_writedata[31:16];

  // Command decode; abort suppresses the sample tick so the FIFO is left untouched
  assign ctrl_wr_c = avs_s0_write && (avs_s0_address == 2'd0);
  assign abort_c   = ctrl_wr_c && avs_s0_writedata[1];
  assign start_c   = ctrl_wr_c && avs_s0_writedata[0] && !avs_s0_writedata[1] &&
                     (count != 16'd0) && (state != ST_CAPTURE);
  assign flush_c   = ctrl_wr_c && avs_s0_writedata[2];
  assign clr_ovf_c = ctrl_wr_c && avs_s0_writedata[3];
  assign empty_c   = (level == LVL_W'(0));
  assign full_c    = (level == LVL_W'(FIFO_DEPTH));
  assign tick_c    = (state == ST_CAPTURE) && (divider == decim) && !abort_c;
  assign pop_c     = avs_s0_read && (avs_s0_address == 2'd3) && !empty_c;
  assign push_c    = tick_c && !flush_c && (!full_c || pop_c);
  assign drop_c    = tick_c && !flush_c && full_c && !pop_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
    end else begin
      state <= state_next;
      irq   <= (state_next == ST_DONE);
    end
  end

  always_comb begin
    state_next = state;
    if (abort_c) begin
      state_next = ST_IDLE;
    end else if (start_c) begin
      state_next = ST_CAPTURE;
    end else if (tick_c && (remaining == 16'd1)) begin
      state_next = ST_DONE;
    end
  end

  // Input register, divider, sample counter, config registers and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sample    <= '0;
      decim     <= '0;
      count     <= '0;
      divider   <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      sample <= addc_hsmc;
      if (start_c) begin
        divider   <= '0;
        remaining <= count;
      end else if (state == ST_CAPTURE) begin
        if (tick_c) begin
          divider   <= '0;
          remaining <= remaining - 16'd1;
        end else begin
          divider <= divider + 16'd1;
        end
      end
      if (avs_s0_write && (state != ST_CAPTURE)) begin
        if (avs_s0_address == 2'd1) decim <= avs_s0_writedata[15:0];
        if (avs_s0_address == 2'd2) count <= avs_s0_writedata[15:0];
      end
      if (clr_ovf_c) overflow <= 1'b0;
      if (drop_c)    overflow <= 1'b1;
    end
  end

  // FIFO pointers and fill level; flush wins over any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c) begin
        level <= level + LVL_W'(1);
      end else if (pop_c && !push_c) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= sample;
  end

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        2'd0: avs_s0_readdata = {17'b0, 7'(level), 3'b0, full_c, empty_c, overflow,
                                 (state == ST_DONE), (state == ST_CAPTURE)};
        2'd1: avs_s0_readdata = {16'b0, decim};
        2'd2: avs_s0_readdata = {16'b0, count};
        2'd3: if (!empty_c) avs_s0_readdata = {1'b1, {PAD_W{1'b0}}, mem[rd_ptr]};
      endcase
    end
  end

endmodule

// File: tb/tb_addc_capture_ctrl.sv
// Directed self-checking bench for addc_capture_ctrl with a free-running ramp on the ADC bus.
module tb_addc_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [13:0] hsmc;
  logic        irq;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [13:0] base;
  logic [31:0] d;

  addc_capture_ctrl #(.FIFO_DEPTH(16), .DATA_W(14)) dut (
    .clk              (clk),
    .reset            (reset),
    .avs_s0_address   (address),
    .avs_s0_read      (read),
    .avs_s0_write     (write),
    .avs_s0_writedata (wdata),
    .avs_s0_readdata  (rdata),
    .addc_hsmc        (hsmc),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  // Ramp changes 2 time units after each rising edge, so the value seen at a
  // negedge is the one the next rising edge registers.
  initial begin
    hsmc = '0;
    forever begin
      @(posedge clk);
      #2;
      hsmc = hsmc + 14'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    write   = 1'b1;
    address = a;
    wdata   = v;
    @(negedge clk);
    write   = 1'b0;
    wdata   = '0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    read    = 1'b1;
    address = a;
    #1;
    v       = rdata;
    read    = 1'b0;
  endtask

  task automatic pop_read(output logic [31:0] v);
    read    = 1'b1;
    address = 2'd3;
    #1;
    v       = rdata;
    @(negedge clk);
    read    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] smp(input logic [13:0] v);
    return {1'b1, 17'b0, v};
  endfunction

  initial begin
    reset   = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    address = '0;
    wdata   = '0;
    idle(3);
    reset = 1'b0;

    peek(2'd0, d); check("rst_status", d, 32'h0000_0008);
    peek(2'd1, d); check("rst_decim", d, 32'h0);
    peek(2'd2, d); check("rst_count", d, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    bus_write(2'd0, 32'h1);
    idle(1);
    peek(2'd0, d); check("start_count0_ignored", d, 32'h0000_0008);

    // DECIM=3, COUNT=4: pushes at edges 4, 8, 12, 16 after the START edge
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd4);
    base = hsmc;
    bus_write(2'd0, 32'h1);
    peek(2'd1, d); check("decim_rb", d, 32'd3);
    idle(3);
    peek(2'd0, d); check("d3_before_first", d, 32'h0000_0009);
    idle(1);
    peek(2'd0, d); check("d3_first_push", d, 32'h0000_0101);
    idle(11);
    peek(2'd0, d); check("d3_three", d, 32'h0000_0301);
    idle(1);
    peek(2'd0, d); check("d3_done", d, 32'h0000_0402);
    check("d3_irq", {31'b0, irq}, 32'h1);
    pop_read(d); check("d3_s0", d, smp(base + 14'd3));
    pop_read(d); check("d3_s1", d, smp(base + 14'd7));
    pop_read(d); check("d3_s2", d, smp(base + 14'd11));
    pop_read(d); check("d3_s3", d, smp(base + 14'd15));
    peek(2'd0, d); check("d3_drained", d, 32'h0000_000A);

    // DECIM=0, COUNT=20, no reads: 16 stored, 4 dropped
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd20);
    base = hsmc;
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'h55);
    idle(18);
    peek(2'd0, d); check("ovf_busy", d, 32'h0000_1015);
    idle(1);
    peek(2'd0, d); check("ovf_done", d, 32'h0000_1016);
    check("ovf_irq", {31'b0, irq}, 32'h1);
    peek(2'd1, d); check("decim_wr_in_capture_ignored", d, 32'h0);

    // Push into a full FIFO with a same-cycle pop: both happen, no overflow
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h9);
    pop_read(d); check("full_pop_head", d, smp(base));
    peek(2'd0, d); check("full_push_pop", d, 32'h0000_1012);
    pop_read(d); check("full_pop_next", d, smp(base + 14'd1));

    // Flush, then DATA read on an empty FIFO
    bus_write(2'd0, 32'h4);
    peek(2'd0, d); check("flush_status", d, 32'h0000_000A);
    pop_read(d); check("empty_data", d, 32'h0);
    peek(2'd0, d); check("empty_level", d, 32'h0000_000A);

    // DECIM=0, COUNT=20 with a DATA read every cycle
    bus_write(2'd2, 32'd20);
    base = hsmc;
    bus_write(2'd0, 32'h1);
    read    = 1'b1;
    address = 2'd3;
    #1;
    check("stream_pre", rdata, 32'h0);
    for (int k = 2; k <= 21; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("stream_s%0d", k - 2), rdata, smp(base + 14'(k - 2)));
    end
    @(negedge clk);
    read = 1'b0;
    peek(2'd0, d); check("stream_end", d, 32'h0000_000A);

    // ABORT together with START mid-capture
    bus_write(2'd0, 32'h4);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd10);
    bus_write(2'd0, 32'h1);
    idle(4);
    peek(2'd0, d); check("abort_pre", d, 32'h0000_0201);
    bus_write(2'd0, 32'h3);
    peek(2'd0, d); check("abort_idle", d, 32'h0000_0200);
    check("abort_irq", {31'b0, irq}, 32'h0);
    idle(4);
    peek(2'd0, d); check("abort_hold", d, 32'h0000_0200);

    // Reset mid-capture with 3 samples stored, overriding a COUNT write
    bus_write(2'd0, 32'h4);
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd10);
    bus_write(2'd0, 32'h1);
    idle(3);
    peek(2'd0, d); check("rst_mid_pre", d, 32'h0000_0301);
    reset   = 1'b1;
    write   = 1'b1;
    address = 2'd2;
    wdata   = 32'd5;
    @(negedge clk);
    reset   = 1'b0;
    write   = 1'b0;
    wdata   = '0;
    peek(2'd0, d); check("rst_mid_status", d, 32'h0000_0008);
    peek(2'd1, d); check("rst_mid_decim", d, 32'h0);
    peek(2'd2, d); check("rst_mid_count", d, 32'h0);
    check("rst_mid_irq", {31'b0, irq}, 32'h0);
    idle(3);
    peek(2'd0, d); check("rst_mid_no_push", d, 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
